// File: rtl/dds_sweep_if.sv
// Sweep controller bundle between the control logic (master) and the sweep
// sequencer (slave).
//   master drives : start, abort, mode, f_start, f_stop, f_step, dwell
//   slave drives  : P, val_out, ena_ac, busy, done, wrap, err
interface dds_sweep_if #(
  parameter int unsigned M = 24,
  parameter int unsigned D = 16
) ();

  logic         start;
  logic         abort;
  logic [1:0]   mode;
  logic [M-1:0] f_start;
  logic [M-1:0] f_stop;
  logic [M-1:0] f_step;
  logic [D-1:0] dwell;

  logic [M-1:0] P;
  logic         val_out;
  logic         ena_ac;
  logic         busy;
  logic         done;
  logic         wrap;
  logic         err;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell,
    input  P, val_out, ena_ac, busy, done, wrap, err
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell,
    output P, val_out, ena_ac, busy, done, wrap, err
  );

endinterface

// File: rtl/dds_sweep_ctrl.sv
// Phase-increment sequencer feeding a DDS: produces a stepped linear chirp
// (single, repeating sawtooth or continuous triangle) as M-bit tuning words.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sw     : dds_sweep_if.slave
//            in  start/abort/mode/f_start/f_stop/f_step/dwell
//            out P (tuning word), val_out (DDS val_in), ena_ac (accumulator
//                enable), busy, done/wrap/err (one-cycle pulses)
// Every output comes straight from a flop.
module dds_sweep_ctrl #(
  parameter int unsigned M = 24,
  parameter int unsigned D = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  dds_sweep_if.slave sw
);

  localparam int unsigned MX = M + 1;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  state_e       state_q, state_d;
  dir_e         dir_q, dir_d;
  logic [M-1:0] p_q, p_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic [1:0]   mode_q, mode_d;
  logic [M-1:0] fstart_q, fstart_d;
  logic [M-1:0] fstop_q, fstop_d;
  logic [M-1:0] fstep_q, fstep_d;
  logic [D-1:0] dwell_q, dwell_d;
  logic         val_q, val_d;
  logic         ena_q, ena_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;

  logic [MX-1:0] sum_c;
  logic [MX-1:0] diff_c;
  logic [M-1:0]  up_next_c;
  logic [M-1:0]  dn_next_c;
  logic          reject_c;

  // Saturating neighbours of P; the extra bit keeps both the sum and the
  // borrow from wrapping, so near-full-range settings clamp correctly.
  always_comb begin
    sum_c     = MX'(p_q) + MX'(fstep_q);
    diff_c    = MX'(p_q) - MX'(fstep_q);
    up_next_c = (sum_c > MX'(fstop_q)) ? fstop_q : sum_c[M-1:0];
    dn_next_c = (diff_c[M] || (diff_c[M-1:0] < fstart_q)) ? fstart_q : diff_c[M-1:0];
  end

  // Configurations that can never produce a valid sweep.
  assign reject_c = (sw.mode == MODE_RSVD) || (sw.f_step == '0) || (sw.f_start > sw.f_stop);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dir_q    <= DIR_UP;
      p_q      <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_SINGLE;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      dwell_q  <= '0;
      val_q    <= 1'b0;
      ena_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      dwell_q  <= dwell_d;
      val_q    <= val_d;
      ena_q    <= ena_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  // Next-state, step rule and next output values.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    fstep_d  = fstep_q;
    dwell_d  = dwell_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sw.start && !sw.abort) begin
          if (reject_c) begin
            err_d = 1'b1;
          end else begin
            mode_d   = sw.mode;
            fstart_d = sw.f_start;
            fstop_d  = sw.f_stop;
            fstep_d  = sw.f_step;
            dwell_d  = sw.dwell;
            p_d      = sw.f_start;
            dir_d    = DIR_UP;
            cnt_d    = sw.dwell;
            state_d  = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (sw.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - D'(1);
        end else begin
          cnt_d = dwell_q;
          if (dir_q == DIR_UP) begin
            if (p_q != fstop_q) begin
              p_d = up_next_c;
            end else begin
              // Top endpoint has had its full dwell.
              case (mode_q)
                MODE_REPEAT: begin
                  p_d    = fstart_q;
                  wrap_d = 1'b1;
                end
                MODE_TRI: begin
                  dir_d  = DIR_DN;
                  p_d    = dn_next_c;
                  wrap_d = 1'b1;
                end
                MODE_SINGLE: state_d = S_DONE;
                default:     state_d = S_DONE;
              endcase
            end
          end else if (p_q != fstart_q) begin
            p_d = dn_next_c;
          end else begin
            // Bottom turn of a triangle: step straight back up.
            dir_d  = DIR_UP;
            p_d    = up_next_c;
            wrap_d = 1'b1;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    val_d  = (state_d == S_HOLD);
    ena_d  = (state_d == S_HOLD);
    busy_d = (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  assign sw.P       = p_q;
  assign sw.val_out = val_q;
  assign sw.ena_ac  = ena_q;
  assign sw.busy    = busy_q;
  assign sw.done    = done_q;
  assign sw.wrap    = wrap_q;
  assign sw.err     = err_q;

endmodule
